// File: rtl/pcie_ss_err_report_seq.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | pcie_ss_err_report_seq: queues error events and replays each one as a    |
// | six-write CSR sequence (4 header dwords, error code, ERROR_GEN_CTL).      |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module pcie_ss_err_report_seq #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 20,
  parameter int                HDR_W     = 128,
  parameter int                PF_W      = 3,
  parameter int                VF_W      = 11,
  parameter logic [ADDR_W-1:0] HDR_BASE  = ADDR_W'(20'h100),
  parameter logic [ADDR_W-1:0] CODE_ADDR = ADDR_W'(20'h110),
  parameter logic [ADDR_W-1:0] CTL_ADDR  = ADDR_W'(20'h114),
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_err_valid,
  input  logic [HDR_W-1:0]  i_err_hdr,
  input  logic [PF_W-1:0]   i_err_pf,
  input  logic [VF_W-1:0]   i_err_vf,
  input  logic              i_err_vf_active,
  input  logic [31:0]       i_err_code,
  output logic              o_wr_valid,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [31:0]       o_wr_data,
  input  logic              i_wr_ready,
  input  logic              i_wr_done,
  input  logic [1:0]        i_wr_bresp,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_drop_cnt,
  output logic [CNT_W-1:0]  o_fail_cnt
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_POP  = 2'd3
  } state_t;

  logic [HDR_W-1:0]  fifo_hdr_q  [DEPTH];
  logic [PF_W-1:0]   fifo_pf_q   [DEPTH];
  logic [VF_W-1:0]   fifo_vf_q   [DEPTH];
  logic              fifo_vfa_q  [DEPTH];
  logic [31:0]       fifo_code_q [DEPTH];

  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic [CNT_W-1:0]  drop_q, fail_q;
  state_t            state_q;
  logic [2:0]        idx_q, idx_nxt;
  logic [HDR_W-1:0]  hdr_q;
  logic [31:0]       code_q, ctl_q;
  logic              wr_valid_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;

  logic              fifo_full, fifo_empty, push, pop;
  logic [31:0]       head_ctl;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [2:0] idx);
    case (idx)
      3'd4:    addr_of = CODE_ADDR;
      3'd5:    addr_of = CTL_ADDR;
      default: addr_of = HDR_BASE + ADDR_W'({idx[1:0], 2'b00});
    endcase
  endfunction

  function automatic logic [31:0] data_of(input logic [2:0] idx, input logic [HDR_W-1:0] hdr,
                                          input logic [31:0] code, input logic [31:0] ctl);
    case (idx)
      3'd0:    data_of = hdr[31:0];
      3'd1:    data_of = hdr[63:32];
      3'd2:    data_of = hdr[95:64];
      3'd3:    data_of = hdr[127:96];
      3'd4:    data_of = code;
      default: data_of = ctl;
    endcase
  endfunction

  // Full is judged on the pre-pop occupancy, so a push racing a pop at full is lost.
  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign push       = i_err_valid && !fifo_full;
  assign pop        = (state_q == S_POP);
  assign idx_nxt    = idx_q + 3'd1;
  assign head_ctl   = {16'(fifo_vf_q[rd_ptr_q]), 8'(fifo_pf_q[rd_ptr_q]), 6'b0,
                       fifo_vfa_q[rd_ptr_q], 1'b1};

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + (AW+1)'(1);
    else if (!push && pop)
      count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_hdr_q[wr_ptr_q]  <= i_err_hdr;
      fifo_pf_q[wr_ptr_q]   <= i_err_pf;
      fifo_vf_q[wr_ptr_q]   <= i_err_vf;
      fifo_vfa_q[wr_ptr_q]  <= i_err_vf_active;
      fifo_code_q[wr_ptr_q] <= i_err_code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      count_q <= count_d;
      if (push)
        wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + AW'(1);
      if (i_err_valid && fifo_full && drop_q != {CNT_W{1'b1}})
        drop_q <= drop_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      hdr_q      <= '0;
      code_q     <= '0;
      ctl_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      fail_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (!fifo_empty) begin
          hdr_q      <= fifo_hdr_q[rd_ptr_q];
          code_q     <= fifo_code_q[rd_ptr_q];
          ctl_q      <= head_ctl;
          idx_q      <= 3'd0;
          wr_valid_q <= 1'b1;
          wr_addr_q  <= addr_of(3'd0);
          wr_data_q  <= fifo_hdr_q[rd_ptr_q][31:0];
          state_q    <= S_REQ;
        end
        S_REQ: if (i_wr_ready) begin
          wr_valid_q <= 1'b0;
          state_q    <= S_RESP;
        end
        S_RESP: if (i_wr_done) begin
          // A rejected write ends the sequence early so the trigger is never issued.
          if (i_wr_bresp != 2'b00) begin
            if (fail_q != {CNT_W{1'b1}})
              fail_q <= fail_q + CNT_W'(1);
            state_q <= S_POP;
          end else if (idx_q == 3'd5) begin
            state_q <= S_POP;
          end else begin
            idx_q      <= idx_nxt;
            wr_valid_q <= 1'b1;
            wr_addr_q  <= addr_of(idx_nxt);
            wr_data_q  <= data_of(idx_nxt, hdr_q, code_q, ctl_q);
            state_q    <= S_REQ;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_wr_valid = wr_valid_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_busy     = !fifo_empty || (state_q != S_IDLE);
  assign o_drop_cnt = drop_q;
  assign o_fail_cnt = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_pcie_ss_err_report_seq.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_pcie_ss_err_report_seq: directed bench for the error-report sequencer. |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_pcie_ss_err_report_seq;

  logic         clk, rst;
  logic         i_err_valid, i_err_vf_active;
  logic [127:0] i_err_hdr;
  logic [2:0]   i_err_pf;
  logic [10:0]  i_err_vf;
  logic [31:0]  i_err_code;
  logic         o_wr_valid, i_wr_ready, i_wr_done, o_busy;
  logic [19:0]  o_wr_addr;
  logic [31:0]  o_wr_data;
  logic [1:0]   i_wr_bresp;
  logic [15:0]  o_drop_cnt, o_fail_cnt;

  pcie_ss_err_report_seq dut (
    .clk(clk), .rst(rst), .i_err_valid(i_err_valid), .i_err_hdr(i_err_hdr),
    .i_err_pf(i_err_pf), .i_err_vf(i_err_vf), .i_err_vf_active(i_err_vf_active),
    .i_err_code(i_err_code), .o_wr_valid(o_wr_valid), .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data), .i_wr_ready(i_wr_ready), .i_wr_done(i_wr_done),
    .i_wr_bresp(i_wr_bresp), .o_busy(o_busy), .o_drop_cnt(o_drop_cnt),
    .o_fail_cnt(o_fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  logic [127:0] ev_hdr  [16];
  logic [2:0]   ev_pf   [16];
  logic [10:0]  ev_vf   [16];
  logic         ev_vfa  [16];
  logic [31:0]  ev_code [16];

  logic [19:0] log_a[$];
  logic [31:0] log_d[$];
  logic [19:0] exp_a[$];
  logic [31:0] exp_d[$];

  bit          ready_en, auto_done, fail_armed, manual_done;
  logic [19:0] fail_addr, stall_addr, nodone_addr;
  int          stall_left;

  // Slave model: logs accepted writes, answers one cycle later, optional stalls/errors.
  initial begin : responder
    bit          hs;
    logic [19:0] hs_addr;
    i_wr_ready = 1'b0;
    i_wr_done  = 1'b0;
    i_wr_bresp = 2'b00;
    forever begin
      @(negedge clk);
      hs      = o_wr_valid && i_wr_ready && !rst;
      hs_addr = o_wr_addr;
      if (hs) begin
        log_a.push_back(o_wr_addr);
        log_d.push_back(o_wr_data);
      end
      @(posedge clk);
      #1;
      i_wr_done  = manual_done;
      i_wr_bresp = manual_done ? 2'b10 : 2'b00;
      if (hs && auto_done && hs_addr != nodone_addr) begin
        i_wr_done = 1'b1;
        if (fail_armed && hs_addr == fail_addr) begin
          i_wr_bresp = 2'b10;
          fail_armed = 1'b0;
        end
      end
      if (!ready_en)
        i_wr_ready = 1'b0;
      else if (o_wr_valid && o_wr_addr == stall_addr && stall_left > 0) begin
        i_wr_ready = 1'b0;
        stall_left--;
      end else
        i_wr_ready = 1'b1;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [19:0] e_addr(input int k);
    if (k < 4) return 20'h100 + 20'(4 * k);
    return (k == 4) ? 20'h110 : 20'h114;
  endfunction

  function automatic logic [31:0] e_data(input int n, input int k);
    logic [127:0] h;
    h = ev_hdr[n];
    if (k < 4) return h[32*k +: 32];
    if (k == 4) return ev_code[n];
    return (32'(ev_vf[n]) << 16) | (32'(ev_pf[n]) << 8) | (32'(ev_vfa[n]) << 1) | 32'd1;
  endfunction

  task automatic add_exp(input int n, input int nw);
    for (int k = 0; k < nw; k++) begin
      exp_a.push_back(e_addr(k));
      exp_d.push_back(e_data(n, k));
    end
  endtask

  task automatic drive_ev(input int n);
    i_err_valid     = 1'b1;
    i_err_hdr       = ev_hdr[n];
    i_err_pf        = ev_pf[n];
    i_err_vf        = ev_vf[n];
    i_err_vf_active = ev_vfa[n];
    i_err_code      = ev_code[n];
  endtask

  task automatic push_ev(input int n);
    drive_ev(n);
    @(posedge clk); #1;
    i_err_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_err_valid = 1'b0;
    ready_en = 1'b1; auto_done = 1'b1; fail_armed = 1'b0; manual_done = 1'b0;
    fail_addr = 20'hFFFFF; stall_addr = 20'hFFFFF; nodone_addr = 20'hFFFFF; stall_left = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    log_a.delete(); log_d.delete(); exp_a.delete(); exp_d.delete();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (o_busy && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++;
    if (o_busy) begin
      n_fail++;
      $display("FAIL %s_idle: busy still %b after %0d cycles, want 0", name, o_busy, n);
    end
  endtask

  task automatic wait_ctl_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(i_wr_done && o_wr_addr == 20'h114) && n < 200);
    n_cmp++;
    if (!(i_wr_done && o_wr_addr == 20'h114)) begin
      n_fail++;
      $display("FAIL %s_ctl_done: no CTL response within 200 cycles (addr %h done %b)",
               name, o_wr_addr, i_wr_done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({o_wr_valid, o_wr_addr, o_wr_data, o_busy, o_drop_cnt, o_fail_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b addr=%h data=%h busy=%b drop=%0d fail=%0d, want all 0",
               o_wr_valid, o_wr_addr, o_wr_data, o_busy, o_drop_cnt, o_fail_cnt);
    end
  endtask

  task automatic test_single();
    int n = 0;
    do_reset();
    add_exp(0, 6);
    push_ev(0);
    n_cmp++;
    if (o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy_on: got %b want 1", o_busy);
    end
    while (o_busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++;
    if (n != 14) begin
      n_fail++;
      $display("FAIL single_latency: busy lasted %0d cycles after push, want 14", n);
    end
    n_cmp++;
    if (log_a.size() != 6) begin
      n_fail++;
      $display("FAIL single_count: got %0d writes want 6", log_a.size());
    end
    for (int j = 0; j < 6; j++) begin
      n_cmp++;
      if (j >= log_a.size() || log_a[j] !== exp_a[j] || log_d[j] !== exp_d[j]) begin
        n_fail++;
        $display("FAIL single_wr%0d: got %h:%h want %h:%h", j, log_a[j], log_d[j], exp_a[j], exp_d[j]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    do_reset();
    add_exp(0, 6);
    stall_addr = 20'h108;
    stall_left = 7;
    push_ev(0);
    do begin
      @(negedge clk);
      n++;
    end while (!(o_wr_valid && o_wr_addr == 20'h108) && n < 100);
    for (int k = 0; k < 7; k++) begin
      n_cmp++;
      if (o_wr_valid !== 1'b1 || o_wr_addr !== 20'h108 || o_wr_data !== 32'h22221111) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b %h:%h want v=1 00108:22221111",
                 k, o_wr_valid, o_wr_addr, o_wr_data);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    wait_idle("bp");
    n_cmp++;
    if (log_a.size() != 6) begin
      n_fail++;
      $display("FAIL bp_count: got %0d writes want 6", log_a.size());
    end
    for (int j = 0; j < 6; j++) begin
      n_cmp++;
      if (j >= log_a.size() || log_a[j] !== exp_a[j] || log_d[j] !== exp_d[j]) begin
        n_fail++;
        $display("FAIL bp_wr%0d: got %h:%h want %h:%h", j, log_a[j], log_d[j], exp_a[j], exp_d[j]);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    ready_en = 1'b0;
    for (int e = 1; e <= 4; e++) add_exp(e, 6);
    for (int e = 1; e <= 6; e++) begin
      drive_ev(e);
      @(posedge clk); #1;
    end
    i_err_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (o_drop_cnt !== 16'd2 || o_busy !== 1'b1 || log_a.size() != 0) begin
      n_fail++;
      $display("FAIL ovf_drop: drop=%0d busy=%b writes=%0d, want drop=2 busy=1 writes=0",
               o_drop_cnt, o_busy, log_a.size());
    end
    ready_en = 1'b1;
    wait_idle("ovf");
    n_cmp++;
    if (log_a.size() != 24) begin
      n_fail++;
      $display("FAIL ovf_count: got %0d writes want 24", log_a.size());
    end
    for (int j = 0; j < 24; j++) begin
      n_cmp++;
      if (j >= log_a.size() || log_a[j] !== exp_a[j] || log_d[j] !== exp_d[j]) begin
        n_fail++;
        $display("FAIL ovf_wr%0d: got %h:%h want %h:%h", j, log_a[j], log_d[j], exp_a[j], exp_d[j]);
      end
    end
  endtask

  task automatic test_error_abort();
    do_reset();
    fail_armed = 1'b1;
    fail_addr  = 20'h104;
    add_exp(7, 2);
    add_exp(8, 6);
    drive_ev(7);
    @(posedge clk); #1;
    push_ev(8);
    wait_idle("err");
    n_cmp++;
    if (o_fail_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL err_fail_cnt: got %0d want 1", o_fail_cnt);
    end
    n_cmp++;
    if (log_a.size() != 8) begin
      n_fail++;
      $display("FAIL err_count: got %0d writes want 8", log_a.size());
    end
    for (int j = 0; j < 8; j++) begin
      n_cmp++;
      if (j >= log_a.size() || log_a[j] !== exp_a[j] || log_d[j] !== exp_d[j]) begin
        n_fail++;
        $display("FAIL err_wr%0d: got %h:%h want %h:%h", j, log_a[j], log_d[j], exp_a[j], exp_d[j]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int order[9] = '{0, 1, 2, 3, 5, 6, 7, 8, 9};
    do_reset();
    foreach (order[i]) add_exp(order[i], 6);
    for (int e = 0; e < 4; e++) begin
      drive_ev(e);
      @(posedge clk); #1;
    end
    i_err_valid = 1'b0;
    // First pop happens with the FIFO full: the racing push must be dropped.
    wait_ctl_done("b2b_full");
    push_ev(4);
    n_cmp++;
    if (o_drop_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL b2b_full_pop_drop: drop=%0d want 1", o_drop_cnt);
    end
    // Second pop happens at DEPTH-1: the racing push must be kept.
    wait_ctl_done("b2b_almost");
    push_ev(5);
    n_cmp++;
    if (o_drop_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL b2b_almost_pop_keep: drop=%0d want 1", o_drop_cnt);
    end
    wait_idle("b2b_a");
    for (int e = 6; e <= 9; e++) begin
      drive_ev(e);
      @(posedge clk); #1;
    end
    i_err_valid = 1'b0;
    wait_idle("b2b_b");
    n_cmp++;
    if (log_a.size() != 54) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d writes want 54", log_a.size());
    end
    for (int j = 0; j < 54; j++) begin
      n_cmp++;
      if (j >= log_a.size() || log_a[j] !== exp_a[j] || log_d[j] !== exp_d[j]) begin
        n_fail++;
        $display("FAIL b2b_wr%0d: got %h:%h want %h:%h", j, log_a[j], log_d[j], exp_a[j], exp_d[j]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    do_reset();
    nodone_addr = 20'h10C;
    push_ev(2);
    do begin
      @(negedge clk);
      n++;
    end while (log_a.size() < 4 && n < 100);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    nodone_addr = 20'hFFFFF;
    n_cmp++;
    if ({o_wr_valid, o_wr_addr, o_wr_data, o_busy, o_drop_cnt, o_fail_cnt} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: valid=%b addr=%h data=%h busy=%b drop=%0d fail=%0d, want all 0",
               o_wr_valid, o_wr_addr, o_wr_data, o_busy, o_drop_cnt, o_fail_cnt);
    end
    @(negedge clk);
    manual_done = 1'b1;
    @(negedge clk);
    manual_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (o_fail_cnt !== 16'd0 || o_wr_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_stray_done: fail=%0d valid=%b busy=%b, want 0/0/0",
               o_fail_cnt, o_wr_valid, o_busy);
    end
    log_a.delete(); log_d.delete(); exp_a.delete(); exp_d.delete();
    add_exp(9, 6);
    push_ev(9);
    wait_idle("rst_new");
    n_cmp++;
    if (log_a.size() != 6) begin
      n_fail++;
      $display("FAIL rst_new_count: got %0d writes want 6", log_a.size());
    end
    for (int j = 0; j < 6; j++) begin
      n_cmp++;
      if (j >= log_a.size() || log_a[j] !== exp_a[j] || log_d[j] !== exp_d[j]) begin
        n_fail++;
        $display("FAIL rst_new_wr%0d: got %h:%h want %h:%h", j, log_a[j], log_d[j], exp_a[j], exp_d[j]);
      end
    end
  endtask

  initial begin : main
    rst = 1'b1;
    i_err_valid = 1'b0; i_err_hdr = '0; i_err_pf = '0; i_err_vf = '0;
    i_err_vf_active = 1'b0; i_err_code = '0;
    ready_en = 1'b1; auto_done = 1'b1; fail_armed = 1'b0; manual_done = 1'b0;
    fail_addr = 20'hFFFFF; stall_addr = 20'hFFFFF; nodone_addr = 20'hFFFFF; stall_left = 0;
    for (int n = 0; n < 16; n++) begin
      ev_hdr[n]  = {32'h4000_0000 + 32'(n), 32'h3000_0000 + 32'(n),
                    32'h2000_0000 + 32'(n), 32'h1000_0000 + 32'(n)};
      ev_pf[n]   = 3'(n);
      ev_vf[n]   = 11'(n * 37 + 1);
      ev_vfa[n]  = n[0];
      ev_code[n] = 32'hC0DE_0000 | 32'(n);
    end
    ev_hdr[0]  = 128'h44443333_22221111_DEADBEEF_0000000A;
    ev_pf[0]   = 3'd2;
    ev_vf[0]   = 11'd5;
    ev_vfa[0]  = 1'b1;
    ev_code[0] = 32'h8;

    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_error_abort();
    test_back_to_back();
    test_mid_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
